sobel_gradient_stream: RTL and testbench

SOBEL_GRADIENT_STREAM -- requirements
Module: sobel_gradient_stream

---
 rtl/sobel_gradient_stream.sv | 226 ++++++++++++++++++++++
 tb/tb_sobel_gradient_stream.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_gradient_stream.sv
// -----------------------------------------------------------------------------
// sobel_gradient_stream
//
// Streaming 3x3 Sobel edge detector for raster-order video. Every accepted
// pixel is shifted into two line buffers and a 3x3 window. Once a pixel
// completes a window whose centre is not on the frame border, the window is
// pushed through a three-stage pipeline:
//   stage 1 : gx / gy
//   stage 2 : |gx|, |gy|, sign agreement
//   stage 3 : magnitude and quantised direction (registered outputs)
// The pipeline stages advance every cycle, independent of in_valid. out_valid
// therefore rises exactly three clock edges after the edge that accepted the
// window-completing pixel.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_pixel   unsigned raster-order pixel
//   in_valid   in_pixel is accepted on this edge (gaps allowed)
//   in_sof     start-of-frame, forces the accepted pixel to position (0,0)
//   out_valid  one-cycle strobe qualifying out_mag / out_dir / out_last
//   out_mag    gradient magnitude (|gx|+|gy|, or max + min/2 when MAG_MODE=1)
//   out_dir    quantised direction: 0=0, 1=45, 2=90, 3=135 degrees
//   out_last   marks the final result of a frame
//   sof_err    sticky: in_sof arrived while the position was not (0,0)
// -----------------------------------------------------------------------------
module sobel_gradient_stream #(
    parameter int PIXEL_W  = 8,
    parameter int IMG_W    = 512,
    parameter int IMG_H    = 512,
    parameter int MAG_MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIXEL_W-1:0] in_pixel,
    input  logic               in_valid,
    input  logic               in_sof,
    output logic               out_valid,
    output logic [PIXEL_W+2:0] out_mag,
    output logic [1:0]         out_dir,
    output logic               out_last,
    output logic               sof_err
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = PIXEL_W + 2;  // unsigned weighted column/row sum
    localparam int GW = PIXEL_W + 3;  // signed gradient / unsigned magnitude
    localparam int PW = GW + 10;      // room for |g| * 618

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } dir_e;

    // ------------------------------------------------------------------
    // Position tracking
    // ------------------------------------------------------------------
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          win_done;
    logic          frame_end;

    always_comb begin
        // NOTE: every variable gets a default at the top of the block, so no
        // path through the ifs below can leave one unassigned and infer a latch.
        cur_col = in_sof ? '0 : col_q;  // in_sof pins this pixel to (0,0)
        cur_row = in_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (in_valid) begin
            if (cur_col == COL_MAX) begin
                col_d = '0;
                row_d = (cur_row == ROW_MAX) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    // The accepted pixel is p22; its centre (row-1,col-1) is interior only
    // when both coordinates are at least 2.
    assign win_done  = in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    assign frame_end = in_valid && (cur_row == ROW_MAX) && (cur_col == COL_MAX);

    // ------------------------------------------------------------------
    // Line buffers and 3x3 window
    // ------------------------------------------------------------------
    logic [PIXEL_W-1:0] lb_row1 [IMG_W];  // previous line
    logic [PIXEL_W-1:0] lb_row2 [IMG_W];  // line before that
    logic [PIXEL_W-1:0] win_q   [3][3];   // [row][col], row 0 = oldest line
    logic [PIXEL_W-1:0] up1, up2;

    assign up1 = lb_row1[cur_col];
    assign up2 = lb_row2[cur_col];

    // NOTE: the line buffers and window are left out of reset; border
    // suppression keeps stale contents from ever reaching the output.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb_row2[cur_col] <= up1;
            lb_row1[cur_col] <= in_pixel;
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= up2;
            win_q[1][2] <= up1;
            win_q[2][2] <= in_pixel;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: signed gradients
    // ------------------------------------------------------------------
    logic [SW-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;

    always_comb begin
        gx_pos = SW'(win_q[0][2]) + (SW'(win_q[1][2]) << 1) + SW'(win_q[2][2]);
        gx_neg = SW'(win_q[0][0]) + (SW'(win_q[1][0]) << 1) + SW'(win_q[2][0]);
        gy_pos = SW'(win_q[2][0]) + (SW'(win_q[2][1]) << 1) + SW'(win_q[2][2]);
        gy_neg = SW'(win_q[0][0]) + (SW'(win_q[0][1]) << 1) + SW'(win_q[0][2]);
        gx_d   = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
        gy_d   = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    end

    // ------------------------------------------------------------------
    // Stage 2: absolute values and sign agreement
    // ------------------------------------------------------------------
    logic [GW-1:0] ax_d, ay_d, ax_q, ay_q;
    logic          same_sign_d, same_sign_q;

    always_comb begin
        ax_d        = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
        ay_d        = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
        // Zero cases never reach the diagonal decision: gy=0 resolves to 0 deg
        // and gx=0 (with gy!=0) resolves to 90 deg.
        same_sign_d = (gx_q[GW-1] == gy_q[GW-1]);
    end

    // ------------------------------------------------------------------
    // Stage 3: magnitude and direction
    // ------------------------------------------------------------------
    logic [GW-1:0] mx, mn, mag_d;
    logic [PW-1:0] ax_w, ay_w;
    dir_e          dir_d;

    always_comb begin
        mx    = (ax_q > ay_q) ? ax_q : ay_q;
        mn    = (ax_q > ay_q) ? ay_q : ax_q;
        mag_d = (MAG_MODE == 1) ? mx + (mn >> 1) : ax_q + ay_q;

        // tan(22.5 deg) ~ 106/256 and tan(67.5 deg) ~ 618/256
        ax_w  = PW'(ax_q);
        ay_w  = PW'(ay_q);
        if ((ay_w << 8) <= ax_w * PW'(106)) begin
            dir_d = DIR_0;
        end else if ((ay_w << 8) >= ax_w * PW'(618)) begin
            dir_d = DIR_90;
        end else if (same_sign_q) begin
            dir_d = DIR_45;
        end else begin
            dir_d = DIR_135;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers (no reset needed, qualified by the valid chain)
    // ------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments so each register
    // samples the pre-edge value of the one feeding it.
    always_ff @(posedge clk) begin
        gx_q        <= gx_d;
        gy_q        <= gy_d;
        ax_q        <= ax_d;
        ay_q        <= ay_d;
        same_sign_q <= same_sign_d;
    end

    // ------------------------------------------------------------------
    // Control registers: position, valid/last chain, outputs, error flag
    // ------------------------------------------------------------------
    logic win_vld_q, s1_vld_q, s2_vld_q;
    logic win_last_q, s1_last_q, s2_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            win_vld_q  <= 1'b0;
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            win_last_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_last_q  <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_mag    <= '0;
            out_dir    <= '0;
            sof_err    <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            win_vld_q  <= win_done;
            win_last_q <= frame_end;
            s1_vld_q   <= win_vld_q;
            s1_last_q  <= win_last_q;
            s2_vld_q   <= s1_vld_q;
            s2_last_q  <= s1_last_q;
            out_valid  <= s2_vld_q;
            out_last   <= s2_vld_q && s2_last_q;
            out_mag    <= mag_d;
            out_dir    <= dir_d;
            if (in_valid && in_sof && ((col_q != '0) || (row_q != '0))) begin
                sof_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sobel_gradient_stream.sv
// -----------------------------------------------------------------------------
// tb_sobel_gradient_stream
//
// Drives an 8x6 image stream into two instances (MAG_MODE 0 and 1) sharing
// the same inputs. A reference model keeps the image as a 2D array, computes
// each interior result with plain Sobel arithmetic and queues it together
// with the cycle it must appear on. A monitor on the falling edge pops the
// queue and compares. A table of hand-computed single windows covers the
// direction thresholds; hand-written sequences cover reset, mid-frame
// in_sof and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_sobel_gradient_stream;
    localparam int PW = 8;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int MW = PW + 3;

    localparam int K_FLAT  = 0;
    localparam int K_VSTEP = 1;
    localparam int K_RAMP  = 2;
    localparam int K_HSTEP = 3;
    localparam int K_WIN   = 4;
    localparam int K_RAND  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] in_pixel;
    logic          in_valid;
    logic          in_sof;
    logic          ov0, ol0, se0, ov1, ol1, se1;
    logic [MW-1:0] om0, om1;
    logic [1:0]    od0, od1;

    always #5 clk = ~clk;

    sobel_gradient_stream #(.PIXEL_W(PW), .IMG_W(W), .IMG_H(H), .MAG_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof),
        .out_valid(ov0), .out_mag(om0), .out_dir(od0), .out_last(ol0), .sof_err(se0)
    );

    sobel_gradient_stream #(.PIXEL_W(PW), .IMG_W(W), .IMG_H(H), .MAG_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof),
        .out_valid(ov1), .out_mag(om1), .out_dir(od1), .out_last(ol1), .sof_err(se1)
    );

    typedef struct {
        int cyc;
        int mag0;
        int mag1;
        int dir;
        int last;
    } exp_t;

    typedef struct {
        int mag0;
        int mag1;
        int dir;
    } got_t;

    typedef struct {
        logic [8:0][7:0] w;  // index r*3+c
        int              mag0;
        int              mag1;
        int              dir;
    } vec_t;

    exp_t            exp_q[$];
    got_t            got_q[$];
    vec_t            tbl[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc    = 0;
    int              n_out  = 0;
    int              img[H][W];
    int              mr = 0;
    int              mc = 0;
    logic [8:0][7:0] cur_win;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic exp_t compute(input int r, input int c, input int acc);
        exp_t e;
        int   w[3][3];
        int   gx, gy, ax, ay, mx, mn;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i][j] = img[r-2+i][c-2+j];
        gx = (w[0][2] + 2*w[1][2] + w[2][2]) - (w[0][0] + 2*w[1][0] + w[2][0]);
        gy = (w[2][0] + 2*w[2][1] + w[2][2]) - (w[0][0] + 2*w[0][1] + w[0][2]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        mx = (ax > ay) ? ax : ay;
        mn = (ax > ay) ? ay : ax;
        e.cyc  = acc + 3;
        e.mag0 = ax + ay;
        e.mag1 = mx + mn / 2;
        if (ay*256 <= ax*106)      e.dir = 0;
        else if (ay*256 >= ax*618) e.dir = 2;
        else if ((gx > 0) == (gy > 0)) e.dir = 1;
        else                       e.dir = 3;
        e.last = (r == H-1 && c == W-1) ? 1 : 0;
        return e;
    endfunction

    task automatic model_accept(input int pix, input bit sof, input int acc);
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = pix;
        if (mr >= 2 && mc >= 2) exp_q.push_back(compute(mr, mc, acc));
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        got_t g;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("missing_output", 0, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (ov0 || ov1) check("valid_mode1", int'(ov1), int'(ov0));
        if (ov0) begin
            n_out++;
            g.mag0 = int'(om0);
            g.mag1 = int'(om1);
            g.dir  = int'(od0);
            got_q.push_back(g);
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_cycle", cyc, e.cyc);
                check("out_mag_mode0", int'(om0), e.mag0);
                check("out_mag_mode1", int'(om1), e.mag1);
                check("out_dir", int'(od0), e.dir);
                check("out_dir_mode1", int'(od1), e.dir);
                check("out_last", int'(ol0), e.last);
                check("out_last_mode1", int'(ol1), e.last);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic int pix_of(input int kind, input int r, input int c);
        int rr, cc;
        rr = (r > 2) ? 2 : r;
        cc = (c > 2) ? 2 : c;
        case (kind)
            K_FLAT:  return 100;
            K_VSTEP: return (c >= 4) ? 255 : 0;
            K_RAMP:  return 10 * (r + c);
            K_HSTEP: return (r >= 3) ? 200 : 0;
            K_WIN:   return int'(cur_win[rr*3 + cc]);
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic send_pixel(input int pix, input bit sof);
        @(negedge clk);
        in_pixel = 8'(pix);
        in_valid = 1'b1;
        in_sof   = sof;
        model_accept(pix, sof, cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'($urandom_range(0, 1));  // ignored without in_valid
            in_pixel = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic send_frame(input int kind, input int gap);
        for (int i = 0; i < W*H; i++) begin
            send_pixel(pix_of(kind, i / W, i % W), i == 0);
            if (gap == 1) idle(1);
            else if (gap == 2) idle($urandom_range(0, 2));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) idle(1);
        idle(2);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic frame_test(input string name, input int kind, input int gap);
        int n0;
        n0 = n_out;
        send_frame(kind, gap);
        drain();
        check(name, n_out - n0, (H-2)*(W-2));
    endtask

    task automatic add_vec(input int p00, input int p01, input int p02,
                           input int p10, input int p11, input int p12,
                           input int p20, input int p21, input int p22,
                           input int m0, input int m1, input int d);
        vec_t v;
        v.w[0] = 8'(p00); v.w[1] = 8'(p01); v.w[2] = 8'(p02);
        v.w[3] = 8'(p10); v.w[4] = 8'(p11); v.w[5] = 8'(p12);
        v.w[6] = 8'(p20); v.w[7] = 8'(p21); v.w[8] = 8'(p22);
        v.mag0 = m0;
        v.mag1 = m1;
        v.dir  = d;
        tbl.push_back(v);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = '0;

        // Hand-computed windows: pixels, |gx|+|gy|, max+min/2, direction.
        add_vec(  0,  0,  0,   0,  0,  0,    0,  0,  0,    0,    0, 0);
        add_vec(  0,  0,255,   0,  0,255,    0,  0,255, 1020, 1020, 0);
        add_vec(  0,  0,  0,   0,  0,  0,  255,255,255, 1020, 1020, 2);
        add_vec(  0,  0,  0,   0,  0,100,    0,100,100,  600,  450, 1);
        add_vec(  0,  0,  0, 100,  0,  0,  100,100,  0,  600,  450, 3);
        add_vec(  0,  0,  0,   0,  0,128,    0, 53,  0,  362,  309, 0);  // on 22.5 deg bound
        add_vec(  0,  0,  0,   0,  0,128,    0, 54,  0,  364,  310, 1);
        add_vec(  0,  0,  0,   0,  0,  1,    0,182,254,  874,  746, 2);  // on 67.5 deg bound
        add_vec(  0,  0,  0,   0,  0,  1,    0,181,254,  872,  744, 1);
        add_vec(255,  0,  0, 255,  0,  0,  255,  0,  0, 1020, 1020, 0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(ov0), 0);
        check("rst_out_last", int'(ol0), 0);
        check("rst_out_mag", int'(om0), 0);
        check("rst_out_dir", int'(od0), 0);
        check("rst_sof_err", int'(se0), 0);
        rst = 1'b0;
        idle(2);

        // Spec patterns, back-to-back and with gaps
        frame_test("flat_count", K_FLAT, 0);
        frame_test("vstep_count", K_VSTEP, 0);
        frame_test("ramp_count", K_RAMP, 0);
        frame_test("hstep_alt_count", K_HSTEP, 1);
        for (int i = 0; i < 3; i++) frame_test("rand_count", K_RAND, i % 3);

        // Table of single windows: first result of a clamped frame is the window
        foreach (tbl[i]) begin
            cur_win = tbl[i].w;
            got_q.delete();
            frame_test("tbl_count", K_WIN, 0);
            if (got_q.size() > 0) begin
                check("tbl_mag_mode0", got_q[0].mag0, tbl[i].mag0);
                check("tbl_mag_mode1", got_q[0].mag1, tbl[i].mag1);
                check("tbl_dir", got_q[0].dir, tbl[i].dir);
            end else begin
                check("tbl_no_output", 0, 1);
            end
        end

        // in_sof at pixel 20: sof_err sets, counter realigns
        check("sof_err_clean", int'(se0), 0);
        n0 = n_out;
        for (int i = 0; i < 20; i++) send_pixel(pix_of(K_RAND, 0, 0), i == 0);
        for (int i = 0; i < W*H; i++) send_pixel(pix_of(K_RAND, 0, 0), i == 0);
        drain();
        check("sof_err_set", int'(se0), 1);
        check("sof_err_set_mode1", int'(se1), 1);
        check("sof_realign_count", n_out - n0, 2 + (H-2)*(W-2));
        frame_test("after_sof_count", K_RAND, 2);
        check("sof_err_sticky", int'(se0), 1);

        // Reset pulsed mid-frame with results in flight
        for (int i = 0; i < 30; i++) send_pixel(pix_of(K_RAND, 0, 0), i == 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        mr = 0;
        mc = 0;
        @(negedge clk);
        check("midrst_out_valid", int'(ov0), 0);
        check("midrst_sof_err", int'(se0), 0);
        rst = 1'b0;
        n0  = n_out;
        idle(6);
        check("midrst_no_stale", n_out - n0, 0);
        frame_test("after_rst_count", K_RAND, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
